// File: rtl/writeback_pkg.sv
// writeback_pkg: select encodings, entry layout and helpers
// shared by the writeback buffer and its FIFO.
package writeback_pkg;

  localparam int WB_SEL_WIDTH = 3;

  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_MULT    = 3'd0;
  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_SHIFT   = 3'd1;
  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_LOGICAL = 3'd2;
  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_ADD     = 3'd3;
  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_COMPARE = 3'd4;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic sel_legal(
    input logic [WB_SEL_WIDTH-1:0] sel
  );
    return sel <= WB_SEL_COMPARE;
  endfunction

endpackage

// File: rtl/writeback_buffer_fifo.sv
// wb_fifo: generic synchronous FIFO, async active-high reset.
// Registered count drives full/empty; storage is not reset.
module wb_fifo
  import writeback_pkg::*;
#(
  parameter  int WIDTH = 37,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: selects an FU result, queues {dest,data},
// drains to the RF port. Optional: WRITEBACK_BYPASS_EN.
module writeback_buffer
  import writeback_pkg::*;
#(
  parameter  int R_DATA_WIDTH   = 32,
  parameter  int REG_ADDR_WIDTH = 5,
  parameter  int WB_DEPTH       = 4,
  parameter  int ZERO_REG       = 1,
  localparam int OCC_W          = $clog2(WB_DEPTH) + 1,
  localparam int ENT_W          = REG_ADDR_WIDTH + R_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_e,
  output logic                      ready_e,
  input  logic                      wb_en_e,
  input  logic [WB_SEL_WIDTH-1:0]   wb_sel_e,
  input  logic [REG_ADDR_WIDTH-1:0] dest_e,
  input  logic [R_DATA_WIDTH-1:0]   mult_e,
  input  logic [R_DATA_WIDTH-1:0]   shift_e,
  input  logic [R_DATA_WIDTH-1:0]   logical_e,
  input  logic [R_DATA_WIDTH-1:0]   add_e,
  input  logic [R_DATA_WIDTH-1:0]   compare_e,
  output logic                      rf_wr_valid,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [R_DATA_WIDTH-1:0]   rf_wr_data,
  input  logic                      rf_wr_ready,
  output logic [OCC_W-1:0]          occupancy,
  output logic                      illegal_sel,
  output logic                      idle
);

  logic [R_DATA_WIDTH-1:0]   sel_data;
  logic [ENT_W-1:0]          ent_in;
  logic [ENT_W-1:0]          ent_out;
  logic [REG_ADDR_WIDTH-1:0] head_addr;
  logic [R_DATA_WIDTH-1:0]   head_data;
  logic                      full;
  logic                      empty;
  logic                      accept;
  logic                      keep;
  logic                      push;
  logic                      pop;

  // result select; unused codes yield zero data
  always_comb begin
    sel_data = '0;
    unique case (1'b1)
      (wb_sel_e == WB_SEL_MULT):    sel_data = mult_e;
      (wb_sel_e == WB_SEL_SHIFT):   sel_data = shift_e;
      (wb_sel_e == WB_SEL_LOGICAL): sel_data = logical_e;
      (wb_sel_e == WB_SEL_ADD):     sel_data = add_e;
      (wb_sel_e == WB_SEL_COMPARE): sel_data = compare_e;
      default:                      sel_data = '0;
    endcase
  end

  assign ready_e = ~full;
  assign accept  = valid_e & ready_e;
  assign keep    = wb_en_e &
                   ~((ZERO_REG != 0) && (dest_e == '0));
  assign ent_in  = {dest_e, sel_data};
  assign {head_addr, head_data} = ent_out;
  assign pop     = ~empty & rf_wr_ready;

`ifdef WRITEBACK_BYPASS_EN
  logic byp;

  assign byp  = empty & accept & keep & sel_legal(wb_sel_e);
  assign push = accept & keep & ~(byp & rf_wr_ready);

  // head of queue wins; else forward the live result
  always_comb begin
    rf_wr_valid = ~empty | byp;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    if (!empty) begin
      rf_wr_addr = head_addr;
      rf_wr_data = head_data;
    end else if (byp) begin
      rf_wr_addr = dest_e;
      rf_wr_data = sel_data;
    end
  end
`else
  assign push = accept & keep;

  // outputs come only from registered FIFO state
  always_comb begin
    rf_wr_valid = ~empty;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    if (!empty) begin
      rf_wr_addr = head_addr;
      rf_wr_data = head_data;
    end
  end
`endif

  assign idle = (occupancy == '0) & ~rf_wr_valid;

  // sticky flag for unused select codes on a writing instr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_sel <= 1'b0;
    end else if (accept & wb_en_e & ~sel_legal(wb_sel_e)) begin
      illegal_sel <= 1'b1;
    end
  end

  wb_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(WB_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (ent_in),
    .dout (ent_out),
    .full (full),
    .empty(empty),
    .count(occupancy)
  );

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: random + directed stimulus, queue-based
// reference model, decoupled scoreboard monitor.
module tb_writeback_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e;
  logic        ready_e;
  logic        wb_en_e;
  logic [2:0]  wb_sel_e;
  logic [4:0]  dest_e;
  logic [31:0] mult_e, shift_e, logical_e, add_e, compare_e;
  logic        rf_wr_valid;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_wr_ready;
  logic [2:0]  occupancy;
  logic        illegal_sel;
  logic        idle;

  always #5 clk = ~clk;

  writeback_buffer dut (
    .clk(clk), .rst(rst),
    .valid_e(valid_e), .ready_e(ready_e),
    .wb_en_e(wb_en_e), .wb_sel_e(wb_sel_e), .dest_e(dest_e),
    .mult_e(mult_e), .shift_e(shift_e),
    .logical_e(logical_e), .add_e(add_e),
    .compare_e(compare_e),
    .rf_wr_valid(rf_wr_valid), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .rf_wr_ready(rf_wr_ready),
    .occupancy(occupancy), .illegal_sel(illegal_sel),
    .idle(idle)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        cand;
  bit          cand_valid = 0;
  bit          cand_byp   = 0;
  int          byp_taken  = 0;
  int          byp_seen   = 0;
  bit          ill_m      = 0;
  logic [31:0] res [5];
  int          checks = 0;
  int          errors = 0;

  task automatic check(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(bit v, bit en, int sel, int dest, bit rdy,
                       bit fz, logic [31:0] fd);
    bit acc;
    @(negedge clk);
    valid_e = v; wb_en_e = en; rf_wr_ready = rdy;
    wb_sel_e = 3'(sel); dest_e = 5'(dest);
    res[0] = $urandom; res[1] = $urandom; res[2] = $urandom;
    res[3] = $urandom; res[4] = $urandom;
    if (fz && sel < 5) res[sel] = fd;
    mult_e = res[0]; shift_e = res[1]; logical_e = res[2];
    add_e = res[3]; compare_e = res[4];
    #3;
    acc = v && ready_e;
    cand.a = 5'(dest);
    cand.d = (sel < 5) ? res[sel] : 32'h0;
    cand_byp = (sel < 5);
    cand_valid = acc && en && (dest != 0);
    @(posedge clk);
    if (acc && en && sel >= 5) ill_m = 1;
    if (byp_taken != byp_seen) byp_seen = byp_taken;
    else if (cand_valid) exp_q.push_back(cand);
    cand_valid = 0;
  endtask

  task automatic idle_cyc(int n, bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, rdy, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++)
      drive(0, 0, 0, 0, 1, 0, 0);
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // scoreboard monitor, sampled 1 time unit before each posedge
  initial begin
    forever begin
      bit   ev;
      ent_t h;
      @(negedge clk);
      #4;
      if (!rst) begin
        check("occupancy", occupancy, exp_q.size());
        check("ready_e", ready_e, exp_q.size() < D);
        check("illegal_sel", illegal_sel, ill_m);
`ifndef WRITEBACK_BYPASS_EN
        check("idle", idle, exp_q.size() == 0);
`endif
        ev = 0;
        if (exp_q.size() > 0) begin
          ev = 1; h = exp_q[0];
        end
`ifdef WRITEBACK_BYPASS_EN
        else if (cand_valid && cand_byp) begin
          ev = 1; h = cand;
        end
`endif
        check("rf_wr_valid", rf_wr_valid, ev);
        if (ev) begin
          check("rf_wr_addr", rf_wr_addr, h.a);
          check("rf_wr_data", rf_wr_data, h.d);
          if (rf_wr_ready && rf_wr_valid) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else byp_taken++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; valid_e = 0; wb_en_e = 0; wb_sel_e = 0; dest_e = 0;
    rf_wr_ready = 0; mult_e = 0; shift_e = 0; logical_e = 0;
    add_e = 0; compare_e = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", rf_wr_valid, 0);
    check("rst_addr", rf_wr_addr, 0);
    check("rst_data", rf_wr_data, 0);
    check("rst_occ", occupancy, 0);
    check("rst_ready", ready_e, 1);
    check("rst_idle", idle, 1);
    check("rst_illegal", illegal_sel, 0);
    rst = 0;

    // single write, add result 0xA5 to r7
    drive(1, 1, 3, 7, 1, 1, 32'hA5);
    idle_cyc(3, 1);
    #1 check("t1_idle", idle, 1);

    // fill with RF stalled, then drain in order
    for (int i = 1; i <= 4; i++) drive(1, 1, i - 1, i, 0, 0, 0);
    #1 check("t2_full_ready", ready_e, 0);
    drive(1, 1, 0, 5, 0, 0, 0);
    drive(1, 1, 0, 5, 0, 0, 0);
    #1 check("t2_no_5th", occupancy, 4);
    drain();

    // discarded writes
    drive(1, 1, 2, 0, 1, 0, 0);
    #1 check("t3_zero_occ", occupancy, 0);
    drive(1, 0, 2, 9, 1, 0, 0);
    #1 check("t3_noen_occ", occupancy, 0);
    idle_cyc(2, 1);

    // illegal select writes zero and sticks
    drive(1, 1, 6, 2, 1, 0, 0);
    #1 check("t4_illegal", illegal_sel, 1);
    for (int i = 0; i < 3; i++) drive(1, 1, i, 10 + i, 1, 0, 0);
    drain();
    #1 check("t4_sticky", illegal_sel, 1);

    // steady push/pop at occupancy 2 across pointer wrap
    drive(1, 1, 0, 11, 0, 0, 0);
    drive(1, 1, 1, 12, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, $urandom_range(0, 4), $urandom_range(1, 31),
            1, 0, 0);
      #1 check("t5_occ2", occupancy, 2);
    end
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 7), $urandom_range(0, 31),
            $urandom_range(0, 2) != 0, 0, 0);
    drain();

`ifdef WRITEBACK_BYPASS_EN
    drive(1, 1, 1, 3, 1, 0, 0);
    idle_cyc(2, 1);
`endif

    // async reset mid-drain with three entries queued
    for (int i = 0; i < 3; i++) drive(1, 1, 3, 20 + i, 0, 0, 0);
    @(negedge clk);
    valid_e = 0;
    rf_wr_ready = 1;
    #2 rst = 1;
    #1;
    check("t6_rst_valid", rf_wr_valid, 0);
    check("t6_rst_occ", occupancy, 0);
    exp_q.delete();
    ill_m = 0;
    @(negedge clk);
    rst = 0;
    idle_cyc(4, 1);
    #1 check("t6_illegal_clr", illegal_sel, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
